global_buffer: RTL and testbench

Shared on-chip feature/weight/output memory of the NPU core: 8192 × 256-bit words with three access paths. The external BRAM-controller port loads inputs and reads back results. The internal read port serves the IAGU/WAGU address generators and supports zero-padding. The internal write port stores OAGU results. It sits between the AXI BRAM controller and the compute datapath (NPE/XPE).

---
 rtl/npu_pkg.sv | 23 ++
 rtl/gb_ram.sv | 66 ++++++
 rtl/global_buffer.sv | 127 ++++++++++++
 tb/tb_global_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg
//   Shared constants and types for the NPU core.
//   GB_DATA_W : global buffer word width in bits
//   GB_ADDR_W : global buffer word address width
//   GB_DEPTH  : global buffer depth in words (2**GB_ADDR_W)
package npu_pkg;

   localparam int unsigned GB_DATA_W = 256;
   localparam int unsigned GB_ADDR_W = 13;
   localparam int unsigned GB_DEPTH  = 2 ** GB_ADDR_W;

   typedef logic [GB_DATA_W-1:0] gb_word_t;
   typedef logic [GB_ADDR_W-1:0] gb_addr_t;

   // True when two enabled write requests target the same word.
   function automatic logic gb_write_collision(input logic     we_a,
                                               input gb_addr_t addr_a,
                                               input logic     we_b,
                                               input gb_addr_t addr_b);
      return we_a && we_b && (addr_a == addr_b);
   endfunction

endpackage

// File: rtl/gb_ram.sv
// gb_ram
//   Behavioural DEPTH x DATA_W memory with two write ports and two read ports.
//   Reads are registered and read-first: a read of a word written at the same
//   edge returns the old contents. Read data holds while its enable is low.
//   No reset on the array or the read registers, so it maps to block RAM.
// Ports
//   clk          : clock, rising edge
//   wr_a_en      : write port A enable
//   wr_a_addr    : write port A address
//   wr_a_data    : write port A data
//   wr_b_en      : write port B enable
//   wr_b_addr    : write port B address
//   wr_b_data    : write port B data
//   rd_a_en      : read port A enable
//   rd_a_addr    : read port A address
//   rd_a_data    : read port A registered data
//   rd_b_en      : read port B enable
//   rd_b_addr    : read port B address
//   rd_b_data    : read port B registered data
module gb_ram
   import npu_pkg::*;
#(
   parameter int unsigned DATA_W = GB_DATA_W,
   parameter int unsigned ADDR_W = GB_ADDR_W,
   parameter int unsigned DEPTH  = GB_DEPTH
) (
   input  logic              clk,
   input  logic              wr_a_en,
   input  logic [ADDR_W-1:0] wr_a_addr,
   input  logic [DATA_W-1:0] wr_a_data,
   input  logic              wr_b_en,
   input  logic [ADDR_W-1:0] wr_b_addr,
   input  logic [DATA_W-1:0] wr_b_data,
   input  logic              rd_a_en,
   input  logic [ADDR_W-1:0] rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic              rd_b_en,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Same-address writes from both ports are excluded by the caller.
   always_ff @(posedge clk) begin
      if (wr_a_en) begin
         mem[wr_a_addr] <= wr_a_data;
      end
      if (wr_b_en) begin
         mem[wr_b_addr] <= wr_b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_a_en) begin
         rd_a_data <= mem[rd_a_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rd_b_en) begin
         rd_b_data <= mem[rd_b_addr];
      end
   end

endmodule

// File: rtl/global_buffer.sv
// global_buffer
//   Shared feature/weight/output memory of the NPU core with three concurrent
//   access paths: the external BRAM-controller read/write port, the internal
//   read port (with zero padding) and the internal write port.
//   Both read paths have one cycle of latency and a one-cycle valid pulse.
// Ports
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   i_gb_bramctl_en     : external port access enable
//   i_gb_bramctl_we     : external write (1) / read (0)
//   i_gb_bramctl_addr   : external word address
//   i_gb_bramctl_wdata  : external write data
//   o_gb_bramctl_data   : external read data
//   o_gb_bramctl_vld    : external read data valid
//   i_gb_raddr          : internal read address
//   i_gb_rd_en          : internal read request
//   i_gb_pad_en         : padding read, returns zero
//   i_gb_waddr          : internal write address
//   i_gb_wr_en          : internal write enable
//   i_gb_wdata          : internal write data
//   o_data              : internal read data
//   o_data_vld          : internal read data valid
module global_buffer
   import npu_pkg::*;
#(
   parameter int unsigned DATA_W = GB_DATA_W,
   parameter int unsigned ADDR_W = GB_ADDR_W,
   parameter int unsigned DEPTH  = GB_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_gb_bramctl_en,
   input  logic              i_gb_bramctl_we,
   input  logic [ADDR_W-1:0] i_gb_bramctl_addr,
   input  logic [DATA_W-1:0] i_gb_bramctl_wdata,
   output logic [DATA_W-1:0] o_gb_bramctl_data,
   output logic              o_gb_bramctl_vld,
   input  logic [ADDR_W-1:0] i_gb_raddr,
   input  logic              i_gb_rd_en,
   input  logic              i_gb_pad_en,
   input  logic [ADDR_W-1:0] i_gb_waddr,
   input  logic              i_gb_wr_en,
   input  logic [DATA_W-1:0] i_gb_wdata,
   output logic [DATA_W-1:0] o_data,
   output logic              o_data_vld
);

   logic              ext_wr_req;
   logic              ext_wr;
   logic              ext_rd;
   logic              int_rd;
   logic [DATA_W-1:0] ext_rdata;
   logic [DATA_W-1:0] int_rdata;

   // Valid pulses and the "force zero" selects for the data outputs. The
   // zero selects reset to 1 so both data outputs read 0 out of reset
   // without putting a reset on the RAM read registers.
   logic ext_vld_d, ext_vld_q;
   logic int_vld_d, int_vld_q;
   logic ext_zero_d, ext_zero_q;
   logic int_zero_d, int_zero_q;

   assign ext_wr_req = i_gb_bramctl_en & i_gb_bramctl_we;
   assign ext_rd     = i_gb_bramctl_en & ~i_gb_bramctl_we;
   // Padding reads never touch the array, so the read register keeps its data.
   assign int_rd     = i_gb_rd_en & ~i_gb_pad_en;

   // The internal write wins a same-address collision.
   assign ext_wr = ext_wr_req &
                   ~gb_write_collision(ext_wr_req, i_gb_bramctl_addr, i_gb_wr_en, i_gb_waddr);

   gb_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_gb_ram (
      .clk       (clk),
      .wr_a_en   (ext_wr),
      .wr_a_addr (i_gb_bramctl_addr),
      .wr_a_data (i_gb_bramctl_wdata),
      .wr_b_en   (i_gb_wr_en),
      .wr_b_addr (i_gb_waddr),
      .wr_b_data (i_gb_wdata),
      .rd_a_en   (ext_rd),
      .rd_a_addr (i_gb_bramctl_addr),
      .rd_a_data (ext_rdata),
      .rd_b_en   (int_rd),
      .rd_b_addr (i_gb_raddr),
      .rd_b_data (int_rdata)
   );

   always_comb begin
      ext_vld_d  = ext_rd;
      int_vld_d  = i_gb_rd_en;
      ext_zero_d = ext_zero_q;
      int_zero_d = int_zero_q;
      if (ext_rd) begin
         ext_zero_d = 1'b0;
      end
      // Without a read the selects hold, so the outputs keep their last value.
      if (i_gb_rd_en) begin
         int_zero_d = i_gb_pad_en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext_vld_q  <= 1'b0;
         int_vld_q  <= 1'b0;
         ext_zero_q <= 1'b1;
         int_zero_q <= 1'b1;
      end else begin
         ext_vld_q  <= ext_vld_d;
         int_vld_q  <= int_vld_d;
         ext_zero_q <= ext_zero_d;
         int_zero_q <= int_zero_d;
      end
   end

   always_comb begin
      o_gb_bramctl_vld  = ext_vld_q;
      o_data_vld        = int_vld_q;
      o_gb_bramctl_data = ext_zero_q ? '0 : ext_rdata;
      o_data            = int_zero_q ? '0 : int_rdata;
   end

endmodule

// File: tb/tb_global_buffer.sv
// tb_global_buffer
//   Self-checking bench for global_buffer: directed scenarios plus a random
//   phase, all checked against a word-array reference model.
module tb_global_buffer;

   localparam int unsigned DW = 256;
   localparam int unsigned AW = 13;

   logic          clk;
   logic          rst;
   logic          b_en;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic [DW-1:0] b_data;
   logic          b_vld;
   logic [AW-1:0] raddr;
   logic          rd_en;
   logic          pad_en;
   logic [AW-1:0] waddr;
   logic          wr_en;
   logic [DW-1:0] wdata;
   logic [DW-1:0] data;
   logic          data_vld;

   global_buffer u_dut (
      .clk                (clk),
      .rst                (rst),
      .i_gb_bramctl_en    (b_en),
      .i_gb_bramctl_we    (b_we),
      .i_gb_bramctl_addr  (b_addr),
      .i_gb_bramctl_wdata (b_wdata),
      .o_gb_bramctl_data  (b_data),
      .o_gb_bramctl_vld   (b_vld),
      .i_gb_raddr         (raddr),
      .i_gb_rd_en         (rd_en),
      .i_gb_pad_en        (pad_en),
      .i_gb_waddr         (waddr),
      .i_gb_wr_en         (wr_en),
      .i_gb_wdata         (wdata),
      .o_data             (data),
      .o_data_vld         (data_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: memory contents and the expected output state.
   logic [DW-1:0] mdl [8192];
   logic [DW-1:0] exp_data;
   logic          exp_vld;
   logic [DW-1:0] exp_bdata;
   logic          exp_bvld;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i*32 +: 32] = $urandom;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] w(input int unsigned v);
      logic [DW-1:0] r;
      r = '0;
      r[31:0] = v;
      return r;
   endfunction

   task automatic set_idle();
      b_en = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      rd_en = 0; pad_en = 0; raddr = '0;
      wr_en = 0; waddr = '0; wdata = '0;
   endtask

   // Apply one cycle of stimulus (called just after a rising edge), advance
   // one edge and compare all outputs against the model.
   task automatic drive_cycle(input logic be, input logic bwe, input logic [AW-1:0] ba,
                              input logic [DW-1:0] bwd, input logic rd, input logic pad,
                              input logic [AW-1:0] ra, input logic wr,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      b_en = be; b_we = bwe; b_addr = ba; b_wdata = bwd;
      rd_en = rd; pad_en = pad; raddr = ra;
      wr_en = wr; waddr = wa; wdata = wd;
      // Reads see the contents before this cycle's writes.
      exp_vld = rd;
      if (rd) exp_data = pad ? '0 : mdl[ra];
      exp_bvld = be && !bwe;
      if (be && !bwe) exp_bdata = mdl[ba];
      if (be && bwe) mdl[ba] = bwd;
      if (wr) mdl[wa] = wd;   // applied last: internal write wins
      @(posedge clk);
      #1;
      check_eq("data", data, exp_data);
      check_eq("data_vld", w(32'(data_vld)), w(32'(exp_vld)));
      check_eq("bramctl_data", b_data, exp_bdata);
      check_eq("bramctl_vld", w(32'(b_vld)), w(32'(exp_bvld)));
   endtask

   logic [DW-1:0] a5;

   initial begin
      a5 = {32{8'hA5}};
      set_idle();
      exp_data = '0; exp_vld = 0; exp_bdata = '0; exp_bvld = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #2;
      check_eq("rst_data", data, '0);
      check_eq("rst_data_vld", w(32'(data_vld)), '0);
      check_eq("rst_bdata", b_data, '0);
      check_eq("rst_bvld", w(32'(b_vld)), '0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Idle: valids stay low
      for (int i = 0; i < 3; i++) drive_cycle(0, 0, '0, '0, 0, 0, '0, 0, '0, '0);

      // External write then read of 0x0010
      drive_cycle(1, 1, 13'h0010, a5, 0, 0, '0, 0, '0, '0);
      drive_cycle(1, 0, 13'h0010, '0, 0, 0, '0, 0, '0, '0);
      check_eq("ext_rd_a5", b_data, a5);
      check_eq("ext_rd_vld", w(32'(b_vld)), w(1));
      drive_cycle(0, 0, '0, '0, 0, 0, '0, 0, '0, '0);
      check_eq("ext_vld_pulse", w(32'(b_vld)), '0);
      check_eq("ext_data_hold", b_data, a5);

      // Preload 0x1FFC..0x1FFE, internal write 0x1FFF, 4-cycle burst
      for (int i = 0; i < 3; i++)
         drive_cycle(1, 1, AW'(13'h1FFC + i), w(i + 1), 0, 0, '0, 0, '0, '0);
      drive_cycle(0, 0, '0, '0, 0, 0, '0, 1, 13'h1FFF, w(32'h1234));
      for (int i = 0; i < 4; i++) begin
         drive_cycle(0, 0, '0, '0, 1, 0, AW'(13'h1FFC + i), 0, '0, '0);
         check_eq("burst_data", data, (i == 3) ? w(32'h1234) : w(i + 1));
         check_eq("burst_vld", w(32'(data_vld)), w(1));
      end

      // Padding reads
      drive_cycle(0, 0, '0, '0, 1, 1, 13'h0010, 0, '0, '0);
      check_eq("pad_data", data, '0);
      check_eq("pad_vld", w(32'(data_vld)), w(1));
      drive_cycle(0, 0, '0, '0, 0, 1, 13'h0010, 0, '0, '0);
      check_eq("pad_no_rd_vld", w(32'(data_vld)), '0);

      // Same-cycle write collision with read-first internal read
      drive_cycle(1, 1, 13'h0020, w(7), 0, 0, '0, 0, '0, '0);
      drive_cycle(1, 1, 13'h0020, w(1), 1, 0, 13'h0020, 1, 13'h0020, w(2));
      check_eq("coll_read_first", data, w(7));
      drive_cycle(0, 0, '0, '0, 1, 0, 13'h0020, 0, '0, '0);
      check_eq("coll_int_wins", data, w(2));

      // Reset during a read burst
      drive_cycle(0, 0, '0, '0, 1, 0, 13'h1FFC, 0, '0, '0);
      drive_cycle(0, 0, '0, '0, 1, 0, 13'h1FFD, 0, '0, '0);
      #2 rst = 1'b0;
      #1;
      check_eq("midrst_data", data, '0);
      check_eq("midrst_vld", w(32'(data_vld)), '0);
      set_idle();
      @(posedge clk);
      #1;
      check_eq("inrst_vld", w(32'(data_vld)), '0);
      check_eq("inrst_bvld", w(32'(b_vld)), '0);
      rst = 1'b1;
      exp_data = '0; exp_vld = 0; exp_bdata = '0; exp_bvld = 0;
      drive_cycle(0, 0, '0, '0, 1, 0, 13'h1FFF, 0, '0, '0);
      check_eq("post_rst_mem", data, w(32'h1234));
      drive_cycle(1, 0, 13'h0010, '0, 0, 0, '0, 0, '0, '0);
      check_eq("post_rst_ext", b_data, a5);

      // Random phase on a small window so collisions are frequent
      for (int i = 0; i < 16; i++)
         drive_cycle(1, 1, AW'(13'h0100 + i), rand_word(), 0, 0, '0, 0, '0, '0);
      for (int i = 0; i < 400; i++) begin
         logic          r_pad;
         logic [AW-1:0] r_ra;
         r_pad = ($urandom_range(3) == 0);
         r_ra  = r_pad ? AW'($urandom) : AW'(13'h0100 + $urandom_range(15));
         drive_cycle(1'($urandom), 1'($urandom), AW'(13'h0100 + $urandom_range(15)),
                     rand_word(), 1'($urandom), r_pad, r_ra, 1'($urandom),
                     AW'(13'h0100 + $urandom_range(15)), rand_word());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
